cpu_run_monitor: RTL and testbench

- Synthesizable, parametrised run monitor that sits beside the `risc_v` core on the top-level clock.
- It samples the core's program counter and output port every cycle and detects a halt when the PC has stayed unchanged for a programmable number of cycles.
- It counts run cycles and output-port changes, and keeps a circular trace of the most recent distinct PC values for readback.
- It generalises the stall-to-finish check used in simulation into hardware usable on FPGA or by any bench.

---
 rtl/cpu_run_monitor_if.sv | 31 +++
 rtl/cpu_run_monitor.sv | 121 ++++++++++++
 tb/tb_cpu_run_monitor.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_monitor_if.sv
// rtl/cpu_run_monitor_if.sv - sample, status and trace-readback bundle for cpu_run_monitor.
// The master side drives core samples and the trace read index; the slave side is the monitor.
interface cpu_run_monitor_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic            Enable;
  logic            Clear;
  logic [XLEN-1:0] PcCurrent;
  logic [XLEN-1:0] CPUOut;
  logic            Halted;
  logic [CYC_W-1:0] CycleCount;
  logic [15:0]     OutChanges;
  logic [CW-1:0]   TraceCount;
  logic [AW-1:0]   RdAddr;
  logic [XLEN-1:0] RdData;

  modport master (
    output Enable, Clear, PcCurrent, CPUOut, RdAddr,
    input  Halted, CycleCount, OutChanges, TraceCount, RdData
  );

  modport slave (
    input  Enable, Clear, PcCurrent, CPUOut, RdAddr,
    output Halted, CycleCount, OutChanges, TraceCount, RdData
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run monitor: PC-stall halt detection, run/output-change counters, PC trace.
// The trace RAM has no reset; TraceCount gating makes unwritten entries read as 0.
module cpu_run_monitor #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 1,
  parameter int CYC_W       = 32
) (
  input logic              CLK,
  input logic              Reset,
  cpu_run_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALTED} state_t;

  state_t           state;
  logic             halted;
  logic [CYC_W-1:0] cycle_count;
  logic [15:0]      out_changes;
  logic [CW-1:0]    trace_count;
  logic [AW-1:0]    wptr;
  logic [SW-1:0]    stall_cnt;
  logic             pc_valid;
  logic             out_valid;
  logic [XLEN-1:0]  pc_prev;
  logic [XLEN-1:0]  out_prev;
  logic [XLEN-1:0]  trace_mem [DEPTH];

  logic             sample;
  logic             pc_new;
  logic             out_new;
  logic             trace_we;
  logic [SW-1:0]    stall_inc;
  logic [AW-1:0]    rd_idx;

  // PAUSE with Enable high resumes and samples on the same edge, unlike IDLE.
  assign sample    = (state == RUN || state == PAUSE) && bus.Enable && !bus.Clear;
  assign pc_new    = !pc_valid || (bus.PcCurrent != pc_prev);
  assign out_new   = !out_valid || (bus.CPUOut != out_prev);
  assign trace_we  = sample && pc_new;
  assign stall_inc = stall_cnt + 1'b1;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      halted      <= 1'b0;
      cycle_count <= '0;
      out_changes <= '0;
      trace_count <= '0;
      wptr        <= '0;
      stall_cnt   <= '0;
      pc_valid    <= 1'b0;
      out_valid   <= 1'b0;
      pc_prev     <= '0;
      out_prev    <= '0;
    end else if (bus.Clear) begin
      state       <= IDLE;
      halted      <= 1'b0;
      cycle_count <= '0;
      out_changes <= '0;
      trace_count <= '0;
      wptr        <= '0;
      stall_cnt   <= '0;
      pc_valid    <= 1'b0;
      out_valid   <= 1'b0;
      pc_prev     <= '0;
      out_prev    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Enable) state <= RUN;
        end
        RUN, PAUSE: begin
          if (!bus.Enable) begin
            state <= PAUSE;
          end else begin
            state <= RUN;
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (pc_new) begin
              pc_prev   <= bus.PcCurrent;
              pc_valid  <= 1'b1;
              stall_cnt <= '0;
              wptr      <= wptr + 1'b1;
              if (trace_count != CW'(DEPTH)) trace_count <= trace_count + 1'b1;
            end else begin
              stall_cnt <= stall_inc;
              if (stall_inc == SW'(HALT_CYCLES)) begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end
            // The very first output sample only arms the comparison.
            if (out_new) begin
              out_prev  <= bus.CPUOut;
              out_valid <= 1'b1;
              if (out_valid && out_changes != 16'hFFFF) out_changes <= out_changes + 1'b1;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (trace_we) trace_mem[wptr] <= bus.PcCurrent;
  end

  assign rd_idx          = wptr - AW'(1) - bus.RdAddr;
  assign bus.RdData      = (CW'(bus.RdAddr) < trace_count) ? trace_mem[rd_idx] : '0;
  assign bus.Halted      = halted;
  assign bus.CycleCount  = cycle_count;
  assign bus.OutChanges  = out_changes;
  assign bus.TraceCount  = trace_count;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - scoreboard bench for cpu_run_monitor.
// Instance a: DEPTH=4, HALT_CYCLES=1; instance b: DEPTH=16, HALT_CYCLES=3.
module tb_cpu_run_monitor;
  localparam int K_HALT = 0;
  localparam int K_CYC  = 1;
  localparam int K_OUT  = 2;
  localparam int K_TC   = 3;
  localparam int K_RD   = 4;

  typedef struct {
    int          sel;
    int          kind;
    int          addr;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t q[$];

  cpu_run_monitor_if #(.XLEN(32), .DEPTH(4),  .CYC_W(32)) a_if ();
  cpu_run_monitor_if #(.XLEN(32), .DEPTH(16), .CYC_W(32)) b_if ();

  cpu_run_monitor #(.XLEN(32), .DEPTH(4), .HALT_CYCLES(1), .CYC_W(32)) u_a (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (a_if.slave)
  );

  cpu_run_monitor #(.XLEN(32), .DEPTH(16), .HALT_CYCLES(3), .CYC_W(32)) u_b (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic step(input int sel, input logic en, input logic clr,
                      input logic [31:0] pc, input logic [31:0] out);
    if (sel == 0) begin
      a_if.Enable = en; a_if.Clear = clr; a_if.PcCurrent = pc; a_if.CPUOut = out;
    end else begin
      b_if.Enable = en; b_if.Clear = clr; b_if.PcCurrent = pc; b_if.CPUOut = out;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input int kind, input int addr,
                     input logic [63:0] val, input string name);
    exp_t e;
    e.sel = sel; e.kind = kind; e.addr = addr; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    for (int i = 0; i < 30 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_timeout: pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  // Monitor: owns RdAddr, compares DUT outputs against queued expectations.
  initial begin
    exp_t        e;
    logic [63:0] act;
    a_if.RdAddr = '0;
    b_if.RdAddr = '0;
    forever begin
      @(negedge clk);
      while (q.size() != 0) begin
        e = q[0];
        if (e.kind == K_RD) begin
          a_if.RdAddr = 2'(e.addr);
          b_if.RdAddr = 4'(e.addr);
        end
        #1;
        case (e.kind)
          K_HALT:  act = (e.sel != 0) ? 64'(b_if.Halted)     : 64'(a_if.Halted);
          K_CYC:   act = (e.sel != 0) ? 64'(b_if.CycleCount) : 64'(a_if.CycleCount);
          K_OUT:   act = (e.sel != 0) ? 64'(b_if.OutChanges) : 64'(a_if.OutChanges);
          K_TC:    act = (e.sel != 0) ? 64'(b_if.TraceCount) : 64'(a_if.TraceCount);
          default: act = (e.sel != 0) ? 64'(b_if.RdData)     : 64'(a_if.RdData);
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%0d required=%0d", e.name, act, e.val);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] outs [7];
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a_if.Enable = 0; a_if.Clear = 0; a_if.PcCurrent = 0; a_if.CPUOut = 0;
    b_if.Enable = 0; b_if.Clear = 0; b_if.PcCurrent = 0; b_if.CPUOut = 0;
    #5;
    chk(0, K_HALT, 0, 0, "rst_halted");
    chk(0, K_CYC,  0, 0, "rst_cycles");
    chk(0, K_OUT,  0, 0, "rst_outchg");
    chk(0, K_TC,   0, 0, "rst_tracecnt");
    chk(0, K_RD,   0, 0, "rst_rd0");
    chk(1, K_TC,   0, 0, "rst_b_tracecnt");
    drain();
    rst_n = 1'b1;

    // PC 0,4,8,8 with HALT_CYCLES=1
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 4, 0);
    step(0, 1, 0, 8, 0);
    chk(0, K_HALT, 0, 0, "t1_no_halt_yet");
    drain();
    step(0, 1, 0, 8, 0);
    chk(0, K_HALT, 0, 1, "t1_halted");
    chk(0, K_CYC,  0, 4, "t1_cycles");
    chk(0, K_TC,   0, 3, "t1_tracecnt");
    chk(0, K_OUT,  0, 0, "t1_outchg");
    chk(0, K_RD,   0, 8, "t1_rd0");
    chk(0, K_RD,   1, 4, "t1_rd1");
    chk(0, K_RD,   2, 0, "t1_rd2");
    chk(0, K_RD,   3, 0, "t1_rd3_invalid");
    drain();
    step(0, 1, 0, 12, 5);
    chk(0, K_HALT, 0, 1, "t1_sticky");
    chk(0, K_CYC,  0, 4, "t1_frozen_cycles");
    chk(0, K_RD,   0, 8, "t1_frozen_trace");
    drain();
    step(0, 0, 0, 12, 5);

    // HALT_CYCLES=3: PC 0,4,4,4,8,8,8,8
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 4, 0);
    step(1, 1, 0, 4, 0);
    step(1, 1, 0, 4, 0);
    chk(1, K_HALT, 0, 0, "t2_two_repeats");
    drain();
    step(1, 1, 0, 8, 0);
    step(1, 1, 0, 8, 0);
    step(1, 1, 0, 8, 0);
    chk(1, K_HALT, 0, 0, "t2_seventh_sample");
    drain();
    step(1, 1, 0, 8, 0);
    chk(1, K_HALT, 0, 1, "t2_halted");
    chk(1, K_CYC,  0, 8, "t2_cycles");
    chk(1, K_TC,   0, 3, "t2_tracecnt");
    chk(1, K_RD,   0, 8, "t2_rd0");
    chk(1, K_RD,   1, 4, "t2_rd1");
    chk(1, K_RD,   2, 0, "t2_rd2");
    drain();

    // Enable gap with unchanged PC
    step(0, 0, 1, 0, 0);
    chk(0, K_HALT, 0, 0, "t3_clear_halted");
    chk(0, K_CYC,  0, 0, "t3_clear_cycles");
    chk(0, K_TC,   0, 0, "t3_clear_tracecnt");
    chk(0, K_RD,   0, 0, "t3_clear_rd0");
    drain();
    step(0, 1, 0, 8, 0);
    step(0, 1, 0, 8, 0);
    step(0, 0, 0, 8, 0);
    step(0, 0, 0, 8, 0);
    chk(0, K_HALT, 0, 0, "t3_paused_halted");
    chk(0, K_CYC,  0, 1, "t3_paused_cycles");
    chk(0, K_RD,   0, 8, "t3_paused_rd0");
    drain();
    step(0, 1, 0, 8, 0);
    chk(0, K_HALT, 0, 1, "t3_resume_halt");
    chk(0, K_CYC,  0, 2, "t3_resume_cycles");
    chk(0, K_TC,   0, 1, "t3_resume_tracecnt");
    drain();

    // Clear with Enable high: IDLE, then RUN one edge later
    step(0, 1, 1, 100, 0);
    chk(0, K_HALT, 0, 0, "t4_clear_halted");
    chk(0, K_CYC,  0, 0, "t4_clear_cycles");
    drain();
    step(0, 1, 0, 100, 0);
    chk(0, K_CYC,  0, 0, "t4_idle_to_run_cycles");
    chk(0, K_TC,   0, 0, "t4_idle_to_run_tracecnt");
    drain();
    step(0, 1, 0, 100, 0);
    chk(0, K_CYC,  0, 1, "t4_first_sample_cycles");
    chk(0, K_RD,   0, 100, "t4_first_sample_rd0");
    drain();

    // DEPTH=4 wrap with output changes 15,15,30,30,45
    outs[0] = 15; outs[1] = 15; outs[2] = 30; outs[3] = 30;
    outs[4] = 45; outs[5] = 45; outs[6] = 45;
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 32'(4 * i), outs[i]);
    chk(0, K_HALT, 0, 0,  "t5_halted");
    chk(0, K_CYC,  0, 7,  "t5_cycles");
    chk(0, K_TC,   0, 4,  "t5_tracecnt_sat");
    chk(0, K_OUT,  0, 2,  "t5_outchg");
    chk(0, K_RD,   0, 24, "t5_rd0");
    chk(0, K_RD,   1, 20, "t5_rd1");
    chk(0, K_RD,   2, 16, "t5_rd2");
    chk(0, K_RD,   3, 12, "t5_rd3");
    drain();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 28, 60);
    chk(0, K_CYC,  0, 7,  "t5_hold_cycles");
    chk(0, K_OUT,  0, 2,  "t5_hold_outchg");
    chk(0, K_TC,   0, 4,  "t5_hold_tracecnt");
    chk(0, K_RD,   0, 24, "t5_hold_rd0");
    drain();
    step(0, 1, 0, 28, 60);
    chk(0, K_CYC,  0, 8,  "t5_resume_cycles");
    chk(0, K_OUT,  0, 3,  "t5_resume_outchg");
    chk(0, K_RD,   0, 28, "t5_resume_rd0");
    drain();
    step(0, 1, 0, 28, 60);
    chk(0, K_HALT, 0, 1,  "t5_halted_full");
    chk(0, K_CYC,  0, 9,  "t5_halted_cycles");
    chk(0, K_RD,   3, 16, "t5_oldest_rd3");
    drain();

    // Asynchronous reset between edges while halted with a full trace
    #2;
    rst_n = 1'b0;
    chk(0, K_HALT, 0, 0, "t6_async_halted");
    chk(0, K_CYC,  0, 0, "t6_async_cycles");
    chk(0, K_OUT,  0, 0, "t6_async_outchg");
    chk(0, K_TC,   0, 0, "t6_async_tracecnt");
    chk(0, K_RD,   0, 0, "t6_async_rd0");
    chk(0, K_RD,   3, 0, "t6_async_rd3");
    chk(1, K_HALT, 0, 0, "t6_async_b_halted");
    chk(1, K_CYC,  0, 0, "t6_async_b_cycles");
    drain();
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk(0, K_CYC,  0, 0, "t6_post_reset_idle");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
